exc_irq_ctrl: RTL and testbench

- Initiator side of the EX/MEM exception-forwarding interface.
- Decides when to take an external interrupt or an undefined-instruction exception.
- Issues the one-cycle FORWARD pulse that makes EX/MEM write the return address into $26 (Xp). It also issues the flush pulses for IF/ID/EX and the PC redirect to the kernel vector.
- Tracks handler residency until the return instruction (jr $26), then applies a post-return interrupt mask window.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/irq_mask_counter.sv | 34 +++
 rtl/exc_irq_ctrl.sv | 147 ++++++++++++++
 tb/tb_exc_irq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types, encodings and vector defaults shared by the pipeline exception logic.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_e;

    typedef enum logic {
        CAUSE_IRQ = 1'b0,
        CAUSE_EXC = 1'b1
    } exc_cause_e;

    localparam logic [2:0]  PCSRC_NONE      = 3'd0;
    localparam logic [2:0]  PCSRC_IRQ       = 3'd4;
    localparam logic [2:0]  PCSRC_EXC       = 3'd5;
    localparam logic [4:0]  XP_REG          = 5'd26;
    localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h8000_0008;

    // Bit 31 of a PC+4 marks kernel space; either ID or EX in kernel blocks a take.
    function automatic logic is_kernel(input logic pc4_id_msb, input logic pc4_ex_msb);
        return pc4_id_msb | pc4_ex_msb;
    endfunction

endpackage

// File: rtl/irq_mask_counter.sv
// Saturating down-counter with synchronous load; load wins over decrement.
module irq_mask_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             is_zero
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt take controller: issues FORWARD, flushes and the vector
// redirect, then tracks the handler until jr $26 and masks IRQs briefly after.
//
//   state   | meaning
//   IDLE    | user code running, evaluating undef / pending IRQ
//   TAKE    | one-cycle forward + flush + redirect pulse
//   HANDLER | kernel handler running, waiting for jr $26
//   RETURN  | one-cycle return, arms the post-return IRQ mask
module exc_irq_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC     = IRQ_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEFAULT,
    parameter int unsigned MASK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_in,
    input  logic        undef_ID,
    input  logic        eret_ID,
    input  logic        stall_in,
    input  logic [31:0] PC4_ID,
    input  logic [31:0] PC4_EX,
    output logic        FORWARD,
    output logic        Flush_IF,
    output logic        Flush_ID,
    output logic        Flush_EX,
    output logic [2:0]  PCSrc_exc,
    output logic [31:0] ExcPC,
    output logic        irq_ack,
    output logic        in_handler
);

    exc_state_e  state_d, state_q;
    exc_cause_e  cause_d, cause_q;
    logic        pending_d, pending_q;
    logic        forward_d, forward_q;
    logic        flush_d, flush_q;
    logic [2:0]  pcsrc_d, pcsrc_q;
    logic [31:0] exc_pc_d, exc_pc_q;
    logic        irq_ack_d, irq_ack_q;
    logic        in_handler_d, in_handler_q;
    logic        mask_load;
    logic        mask_zero;
    logic        kern;
    logic        unused_pc_bits;

    assign kern           = is_kernel(PC4_ID[31], PC4_EX[31]);
    assign unused_pc_bits = ^{PC4_ID[30:0], PC4_EX[30:0]};

    irq_mask_counter #(
        .WIDTH (4)
    ) u_mask (
        .clk      (clk),
        .reset    (reset),
        .load     (mask_load),
        .load_val (4'(MASK_CYCLES)),
        .is_zero  (mask_zero)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pending_d    = pending_q | irq_in;
        forward_d    = 1'b0;
        flush_d      = 1'b0;
        pcsrc_d      = PCSRC_NONE;
        exc_pc_d     = exc_pc_q;
        irq_ack_d    = 1'b0;
        in_handler_d = 1'b0;
        mask_load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The exception is checked first so it wins over a pending IRQ.
                if (undef_ID && !kern && !stall_in) begin
                    state_d   = ST_TAKE;
                    cause_d   = CAUSE_EXC;
                    forward_d = 1'b1;
                    flush_d   = 1'b1;
                    pcsrc_d   = PCSRC_EXC;
                    exc_pc_d  = EXC_VEC;
                end else if (pending_q && !kern && !stall_in && mask_zero) begin
                    state_d   = ST_TAKE;
                    cause_d   = CAUSE_IRQ;
                    forward_d = 1'b1;
                    flush_d   = 1'b1;
                    pcsrc_d   = PCSRC_IRQ;
                    exc_pc_d  = IRQ_VEC;
                    irq_ack_d = 1'b1;
                end
            end
            ST_TAKE: begin
                if (cause_q == CAUSE_IRQ) begin
                    pending_d = 1'b0;
                end
                state_d      = ST_HANDLER;
                in_handler_d = 1'b1;
            end
            ST_HANDLER: begin
                if (eret_ID && !stall_in) begin
                    state_d = ST_RETURN;
                end else begin
                    in_handler_d = 1'b1;
                end
            end
            ST_RETURN: begin
                mask_load = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cause_q      <= CAUSE_IRQ;
            pending_q    <= 1'b0;
            forward_q    <= 1'b0;
            flush_q      <= 1'b0;
            pcsrc_q      <= PCSRC_NONE;
            exc_pc_q     <= IRQ_VEC;
            irq_ack_q    <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            pending_q    <= pending_d;
            forward_q    <= forward_d;
            flush_q      <= flush_d;
            pcsrc_q      <= pcsrc_d;
            exc_pc_q     <= exc_pc_d;
            irq_ack_q    <= irq_ack_d;
            in_handler_q <= in_handler_d;
        end
    end

    assign FORWARD    = forward_q;
    assign Flush_IF   = flush_q;
    assign Flush_ID   = flush_q;
    assign Flush_EX   = flush_q;
    assign PCSrc_exc  = pcsrc_q;
    assign ExcPC      = exc_pc_q;
    assign irq_ack    = irq_ack_q;
    assign in_handler = in_handler_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl: take timing, priority, kernel block,
// stalled return, post-return mask and mid-operation reset.
module tb_exc_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_in;
    logic        undef_ID;
    logic        eret_ID;
    logic        stall_in;
    logic [31:0] PC4_ID;
    logic [31:0] PC4_EX;
    logic        FORWARD;
    logic        Flush_IF;
    logic        Flush_ID;
    logic        Flush_EX;
    logic [2:0]  PCSrc_exc;
    logic [31:0] ExcPC;
    logic        irq_ack;
    logic        in_handler;

    int total = 0;
    int bad   = 0;

    exc_irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .undef_ID   (undef_ID),
        .eret_ID    (eret_ID),
        .stall_in   (stall_in),
        .PC4_ID     (PC4_ID),
        .PC4_EX     (PC4_EX),
        .FORWARD    (FORWARD),
        .Flush_IF   (Flush_IF),
        .Flush_ID   (Flush_ID),
        .Flush_EX   (Flush_EX),
        .PCSrc_exc  (PCSrc_exc),
        .ExcPC      (ExcPC),
        .irq_ack    (irq_ack),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse vector = {FORWARD, Flush_IF, Flush_ID, Flush_EX, irq_ack}
    task automatic chk_pulses(input string tag, input logic [4:0] exp_pulse, input logic [2:0] exp_src);
        chk({tag, "_pulse"}, 32'({FORWARD, Flush_IF, Flush_ID, Flush_EX, irq_ack}), 32'(exp_pulse));
        chk({tag, "_pcsrc"}, 32'(PCSrc_exc), 32'(exp_src));
    endtask

    task automatic leave_handler();
        eret_ID = 1'b1;
        tick();
        eret_ID = 1'b0;
        tick();
    endtask

    task automatic drain_mask();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        reset    = 1'b1;
        irq_in   = 1'b0;
        undef_ID = 1'b0;
        eret_ID  = 1'b0;
        stall_in = 1'b0;
        PC4_ID   = 32'h0000_0040;
        PC4_EX   = 32'h0000_003c;
        tick();
        tick();
        chk_pulses("reset", 5'b00000, 3'd0);
        chk("reset_excpc", ExcPC, 32'h8000_0004);
        chk("reset_inh", 32'(in_handler), 32'd0);
        reset = 1'b0;

        // basic IRQ: pulse two clocks after irq_in rises
        irq_in = 1'b1;
        tick();
        chk_pulses("irq_latch", 5'b00000, 3'd0);
        irq_in = 1'b0;
        tick();
        chk_pulses("irq_take", 5'b11111, 3'd4);
        chk("irq_take_pc", ExcPC, 32'h8000_0004);
        chk("irq_take_inh", 32'(in_handler), 32'd0);
        tick();
        chk_pulses("irq_after", 5'b00000, 3'd0);
        chk("irq_handler", 32'(in_handler), 32'd1);
        eret_ID = 1'b1;
        tick();
        chk("ret_inh", 32'(in_handler), 32'd0);
        eret_ID = 1'b0;
        tick();

        // undef + irq together: exception wins even inside the mask window
        undef_ID = 1'b1;
        irq_in   = 1'b1;
        tick();
        chk_pulses("exc_take", 5'b11110, 3'd5);
        chk("exc_take_pc", ExcPC, 32'h8000_0008);
        undef_ID = 1'b0;
        irq_in   = 1'b0;
        tick();
        chk("exc_handler", 32'(in_handler), 32'd1);
        tick();
        chk_pulses("exc_hold", 5'b00000, 3'd0);
        leave_handler();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mask1_block", 32'(FORWARD), 32'd0);
        end
        tick();
        chk_pulses("mask1_take", 5'b11111, 3'd4);
        tick();
        leave_handler();
        drain_mask();

        // kernel PC in EX blocks the IRQ until it leaves
        PC4_EX = 32'h8000_0100;
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("kern_block", 32'(FORWARD), 32'd0);
        end
        PC4_EX = 32'h0000_003c;
        tick();
        chk_pulses("kern_take", 5'b11111, 3'd4);
        tick();

        // stalled eret stays in handler, then IRQ at return waits out the mask
        eret_ID  = 1'b1;
        stall_in = 1'b1;
        tick();
        chk("stall_inh1", 32'(in_handler), 32'd1);
        tick();
        chk("stall_inh2", 32'(in_handler), 32'd1);
        stall_in = 1'b0;
        tick();
        chk("stall_ret", 32'(in_handler), 32'd0);
        eret_ID = 1'b0;
        irq_in  = 1'b1;
        tick();
        irq_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mask2_block", 32'(FORWARD), 32'd0);
        end
        tick();
        chk_pulses("mask2_take", 5'b11111, 3'd4);
        tick();
        leave_handler();
        drain_mask();

        // reset during TAKE
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        tick();
        chk("rst_pre_take", 32'(FORWARD), 32'd1);
        reset = 1'b1;
        tick();
        chk_pulses("rst_mid", 5'b00000, 3'd0);
        chk("rst_mid_pc", ExcPC, 32'h8000_0004);
        chk("rst_mid_inh", 32'(in_handler), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_no_pend", 32'(FORWARD), 32'd0);
        tick();
        chk("rst_idle", 32'(in_handler), 32'd0);
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        tick();
        chk_pulses("rst_after_take", 5'b11111, 3'd4);
        tick();
        leave_handler();
        drain_mask();

        // undef in kernel ignored; eret outside handler ignored
        PC4_ID   = 32'h8000_0010;
        undef_ID = 1'b1;
        tick();
        chk_pulses("kundef", 5'b00000, 3'd0);
        tick();
        chk("kundef_idle", 32'(in_handler), 32'd0);
        undef_ID = 1'b0;
        PC4_ID   = 32'h0000_0040;
        eret_ID  = 1'b1;
        tick();
        eret_ID = 1'b0;
        tick();
        chk("eret_idle", 32'(in_handler), 32'd0);

        // stall in IDLE holds off the exception
        undef_ID = 1'b1;
        stall_in = 1'b1;
        tick();
        chk("stall_undef", 32'(FORWARD), 32'd0);
        stall_in = 1'b0;
        tick();
        chk_pulses("unstall_undef", 5'b11110, 3'd5);
        undef_ID = 1'b0;
        tick();
        chk("unstall_inh", 32'(in_handler), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
